// File: rtl/ddr_line_fetch_pkg.sv
// rtl/ddr_line_fetch_pkg.sv - shared constants, FSM state encoding and address helper for ddr_line_fetch
package ddr_line_fetch_pkg;

    localparam int DEF_LINE_WORDS = 256;
    localparam int DEF_LINES      = 224;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Word index to byte address; the sum wraps modulo 2^28 and the base's byte offset is dropped.
    function automatic logic [27:0] word_addr(input logic [27:0] base, input logic [25:0] idx);
        return {base[27:2], 2'b00} + {idx, 2'b00};
    endfunction

endpackage

// File: rtl/ddr_line_fetch.sv
// rtl/ddr_line_fetch.sv - fetches image lines from DDR into a two-bank line buffer ahead of the display
module ddr_line_fetch
    import ddr_line_fetch_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LINES      = DEF_LINES
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [27:0] img_base,
    input  logic        vs,
    input  logic        line_done,
    output logic        ddr_req,
    output logic [27:0] ddr_addr,
    input  logic        ddr_ready,
    input  logic [31:0] ddr_dout,
    output logic        buf_we,
    output logic [8:0]  buf_waddr,
    output logic [31:0] buf_wdata,
    output logic        rd_bank,
    output logic        busy,
    output logic        underrun
);

    localparam int WW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

    state_e        state_q, state_d;
    logic [LW-1:0] line_q, line_d, disp_q, disp_d;
    logic [WW-1:0] word_q, word_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic          pending_q, pending_d, underrun_q, underrun_d;
    logic          old_vs_q, old_vs_d, drain_rst_q, drain_rst_d;
    logic [27:0]   addr_q, addr_d;
    logic          buf_we_q, buf_we_d;
    logic [8:0]    buf_waddr_q, buf_waddr_d;
    logic [31:0]   buf_wdata_q, buf_wdata_d;
    logic          vs_rise, do_restart, do_launch;
    logic [31:0]   nxt_line;

    assign vs_rise = vs & ~old_vs_q;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        disp_d      = disp_q;
        word_d      = word_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        pending_d   = pending_q;
        underrun_d  = underrun_q;
        drain_rst_d = drain_rst_q;
        addr_d      = addr_q;
        old_vs_d    = vs;
        buf_we_d    = 1'b0;
        buf_waddr_d = buf_waddr_q;
        buf_wdata_d = buf_wdata_q;
        do_restart  = 1'b0;
        do_launch   = 1'b0;
        nxt_line    = '0;

        // A released bank is only re-filled once; extra line_done pulses while one is queued just flag underrun.
        if (enable && line_done) begin
            if (!pending_q && disp_q != LAST_LINE) begin
                rd_bank_d = ~rd_bank_q;
                disp_d    = disp_q + LW'(1);
                pending_d = 1'b1;
            end
            if (state_q != ST_IDLE) underrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!enable)                 pending_d  = 1'b0;
                else if (vs_rise)            do_restart = 1'b1;
                else if (pending_d)          do_launch  = 1'b1;
            end
            ST_REQ: begin
                if (!enable)                 state_d    = ST_IDLE;
                else if (vs_rise)            do_restart = 1'b1;
                else                         state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (!enable || vs_rise) begin
                    drain_rst_d = enable & vs_rise;
                    if (!ddr_ready)          state_d    = ST_DRAIN;
                    else if (drain_rst_d)    do_restart = 1'b1;
                    else                     state_d    = ST_IDLE;
                end else if (ddr_ready) begin
                    buf_we_d    = 1'b1;
                    buf_waddr_d = {wr_bank_q, 8'(word_q)};
                    buf_wdata_d = ddr_dout;
                    if (word_q != LAST_WORD) begin
                        word_d  = word_q + WW'(1);
                        state_d = ST_REQ;
                    end else if (line_q == '0 && LINES > 1) begin
                        line_d    = LW'(1);
                        wr_bank_d = 1'b1;
                        word_d    = '0;
                        state_d   = ST_REQ;
                    end else if (pending_d) begin
                        do_launch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                if (enable && vs_rise) drain_rst_d = 1'b1;
                if (!enable)           drain_rst_d = 1'b0;
                if (ddr_ready) begin
                    if (drain_rst_d)   do_restart = 1'b1;
                    else               state_d    = ST_IDLE;
                end
            end
        endcase

        // The line after the one now displayed goes into the bank the display just released.
        if (do_launch) begin
            pending_d = 1'b0;
            nxt_line  = 32'(disp_d) + 32'd1;
            if (nxt_line < 32'(LINES)) begin
                line_d    = nxt_line[LW-1:0];
                wr_bank_d = ~rd_bank_d;
                word_d    = '0;
                state_d   = ST_REQ;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (do_restart) begin
            line_d      = '0;
            disp_d      = '0;
            word_d      = '0;
            wr_bank_d   = 1'b0;
            rd_bank_d   = 1'b0;
            pending_d   = 1'b0;
            drain_rst_d = 1'b0;
            state_d     = ST_REQ;
        end

        if (state_d == ST_REQ)
            addr_d = word_addr(img_base, 26'(line_d) * 26'(LINE_WORDS) + 26'(word_d));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            line_q      <= '0;
            disp_q      <= '0;
            word_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            pending_q   <= 1'b0;
            underrun_q  <= 1'b0;
            drain_rst_q <= 1'b0;
            old_vs_q    <= 1'b0;
            addr_q      <= '0;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            disp_q      <= disp_d;
            word_q      <= word_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            pending_q   <= pending_d;
            underrun_q  <= underrun_d;
            drain_rst_q <= drain_rst_d;
            old_vs_q    <= old_vs_d;
            addr_q      <= addr_d;
            buf_we_q    <= buf_we_d;
            buf_waddr_q <= buf_waddr_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end

    // A request is withdrawn in the cycle it would be overtaken by disable or a new frame.
    assign ddr_req   = (state_q == ST_REQ) && enable && !vs_rise;
    assign ddr_addr  = addr_q;
    assign buf_we    = buf_we_q;
    assign buf_waddr = buf_waddr_q;
    assign buf_wdata = buf_wdata_q;
    assign rd_bank   = rd_bank_q;
    assign busy      = (state_q != ST_IDLE);
    assign underrun  = underrun_q;

endmodule

// File: doc/ddr_line_fetch.md
DDR_LINE_FETCH -- requirements
Module: ddr_line_fetch

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 256: 32-bit words per image line.
REQ-002 SHALL have parameter LINES, default 224: image lines per frame.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-004 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  level; image present in DDR; low forces IDLE and blocks new fetches.
REQ-007 img_base  in  28  byte base address of frame in DDR; bits [1:0] ignored.
REQ-008 vs  in  1  vertical sync level; rising edge = frame start.
REQ-009 line_done  in  1  one-cycle pulse; the display has finished reading the current line.
REQ-010 ddr_req  out  1  one-cycle read request to the DDR channel.
REQ-011 ddr_addr  out  28  byte address of the requested word; low 2 bits zero.
REQ-012 ddr_ready  in  1  one-cycle pulse; ddr_dout is valid.
REQ-013 ddr_dout  in  32  read data.
REQ-014 buf_we, buf_waddr[8:0], buf_wdata[31:0]  out  line-buffer write port; bit 8 = bank, [7:0] = word index.
REQ-015 rd_bank  out  1  bank the display SHALL read.
REQ-016 busy  out  1; underrun  out  1, sticky.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT and DRAIN.
REQ-018 Frame start with enable high: line_cnt=0, wr_bank=0, rd_bank=0, word=0, then fetch line 0 followed automatically by line 1 into bank 1.
REQ-019 REQ: assert ddr_req for exactly one cycle with ddr_addr = img_base + (line*LINE_WORDS + word)*4, then go to WAIT.
REQ-020 ddr_addr SHALL be held stable from the req cycle until the matching ddr_ready.
REQ-021 At most one read SHALL be outstanding.
REQ-022 WAIT, on ddr_ready: buf_we=1 for one cycle with buf_waddr={wr_bank,word} and buf_wdata=ddr_dout.
REQ-023 After that write: if word==LINE_WORDS-1, the line is complete; otherwise word+1 and return to REQ. Next req SHALL appear 1 cycle after ready.
REQ-024 After line 0 completes, line 1 SHALL be fetched into bank 1 without waiting for line_done.
REQ-025 On line_done: toggle rd_bank; the released bank becomes wr_bank; fetch line (displayed+2) if it is < LINES, else go IDLE.
REQ-026 line_done while busy: set underrun, record one pending fetch, start it on completion of the current line; further line_done while pending only sets underrun.
REQ-027 Frame start in WAIT: go to DRAIN; wait for ddr_ready, suppress buf_we, then restart per REQ-018.
REQ-028 Frame start in REQ or IDLE: restart immediately.
REQ-029 enable low: finish any outstanding read via DRAIN without a write, then IDLE. busy=0 in IDLE only.
REQ-030 Arithmetic: line and word counters SHALL be sized by $clog2 of the parameters; address sum SHALL be 28-bit and wrap modulo 2^28.
REQ-031 vs SHALL be edge-detected with one register; no synchronizer.

Reset
REQ-032 reset_n low SHALL set: state=IDLE; ddr_req=0, buf_we=0, busy=0, underrun=0, rd_bank=0; ddr_addr=0; all counters 0; pending=0; old_vs=0.
REQ-033 Reset mid-read SHALL discard the outstanding transaction; the next ready after release with no req SHALL be ignored.

Structure
REQ-034 Package ddr_line_fetch_pkg SHALL hold the FSM state enum and default LINE_WORDS/LINES constants.
REQ-035 Line buffer (dpram, 512x32) SHALL be external; no sub-module is required.

Verification
REQ-036 img_base=0x100, vs rise, ready 3 cycles after each req -> first addr 0x100; bank0 words 0..255 written; next addr 0x500 into bank1.
REQ-037 line_done after both lines are loaded -> rd_bank=1; line 2 fetched into bank0 from addr 0x900; underrun=0.
REQ-038 line_done while line 1 is still fetching -> underrun=1; line 2 starts immediately after line 1's last write.
REQ-039 vs rise while in WAIT -> next ready produces no buf_we; next req addr=img_base.
REQ-040 LINES=4, four line_done pulses -> no fetch beyond line 3; busy=0.
REQ-041 reset_n low mid-fetch -> all outputs at reset values immediately, without a clock edge.
